// File: rtl/ad9228_capture_ctrl.sv
// Capture sequencer for the AD9228 channel read paths: arm, trigger, post-trigger delay,
// then a fixed-length write-enable window shared by every channel FIFO.
module ad9228_capture_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = 16,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   trig_in,
    input  logic                   trig_sw,
    input  logic [DELAY_WIDTH-1:0] delay_cfg,
    input  logic [COUNT_WIDTH-1:0] nsamples_cfg,
    input  logic [NUM_CH-1:0]      fifo_full,
    output logic                   wr_en,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] sample_count,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam logic [DELAY_WIDTH-1:0] DELAY_ONE = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DELAY_WIDTH-1:0] DELAY_ZERO = '0;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = '0;

    state_e                 state_q, state_d;
    logic                   trig_in_q;
    logic [DELAY_WIDTH-1:0] delay_lat_q, delay_lat_d;
    logic [COUNT_WIDTH-1:0] nsamp_lat_q, nsamp_lat_d;
    logic [DELAY_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   wr_en_q, wr_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   trigger;
    logic [COUNT_WIDTH-1:0] count_inc;

    assign trigger   = (trig_in & ~trig_in_q) | trig_sw;
    assign count_inc = count_q + 1'b1;

    // State and datapath registers; the trigger history updates in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            trig_in_q   <= 1'b0;
            delay_lat_q <= '0;
            nsamp_lat_q <= '0;
            delay_cnt_q <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_in_q   <= trig_in;
            delay_lat_q <= delay_lat_d;
            nsamp_lat_q <= nsamp_lat_d;
            delay_cnt_q <= delay_cnt_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        delay_lat_d = delay_lat_q;
        nsamp_lat_d = nsamp_lat_q;
        delay_cnt_d = delay_cnt_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm && (nsamples_cfg != COUNT_ZERO)) begin
                        state_d     = S_ARMED;
                        delay_lat_d = delay_cfg;
                        nsamp_lat_d = nsamples_cfg;
                        overflow_d  = 1'b0;
                        count_d     = '0;
                    end
                end
                S_ARMED: begin
                    if (trigger) begin
                        delay_cnt_d = delay_lat_q;
                        state_d     = (delay_lat_q == DELAY_ZERO) ? S_CAPTURE : S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (delay_cnt_q == DELAY_ONE) begin
                        state_d = S_CAPTURE;
                    end else begin
                        delay_cnt_d = delay_cnt_q - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // The cycle that sees a full flag still issued a write, so it is counted.
                    count_d = count_inc;
                    if (|fifo_full) begin
                        overflow_d = 1'b1;
                        state_d    = S_DONE;
                    end else if (count_inc == nsamp_lat_q) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        wr_en_d = (state_d == S_CAPTURE);
        busy_d  = (state_d == S_ARMED) || (state_d == S_DELAY) || (state_d == S_CAPTURE);
        done_d  = (state_d == S_DONE);
    end

    assign wr_en        = wr_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign sample_count = count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_ad9228_capture_ctrl.sv
// Directed bench for ad9228_capture_ctrl; each scenario task checks its own expectations.
module tb_ad9228_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trig_in = 1'b0;
  logic        trig_sw = 1'b0;
  logic [15:0] delay_cfg = '0;
  logic [15:0] nsamples_cfg = '0;
  logic [3:0]  fifo_full = '0;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] sample_count;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  ad9228_capture_ctrl #(.NUM_CH(4), .COUNT_WIDTH(16), .DELAY_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_in(trig_in), .trig_sw(trig_sw),
    .delay_cfg(delay_cfg), .nsamples_cfg(nsamples_cfg), .fifo_full(fifo_full),
    .wr_en(wr_en), .busy(busy), .done(done), .overflow(overflow),
    .sample_count(sample_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int n, input int d);
    nsamples_cfg = 16'(n);
    delay_cfg = 16'(d);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    nsamples_cfg = 16'hbeef;
    delay_cfg = 16'h0077;
  endtask

  // Counts delay and write cycles from now until done is seen, within a cycle budget.
  task automatic run_to_done(output int n_delay, output int n_wr, output bit timed_out);
    n_delay = 0;
    n_wr = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (state == 3'd2) n_delay++;
      if (wr_en) n_wr++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({wr_en, busy, done, overflow, sample_count, state} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, want all zero", {wr_en, busy, done, overflow, sample_count, state});
    end
  endtask

  task automatic test_basic_hw_trigger();
    int nd, nw;
    bit to;
    do_arm(8, 0);
    vectors++;
    if (state !== 3'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL arm_to_armed: state=%0d busy=%b, want 1/1", state, busy);
    end
    trig_in = 1'b1;
    tick();
    vectors++;
    if (wr_en !== 1'b1 || state !== 3'd3) begin
      miscompares++;
      $display("FAIL first_write_latency: wr_en=%b state=%0d, want 1/3", wr_en, state);
    end
    run_to_done(nd, nw, to);
    vectors++;
    if (to || nw != 8 || nd != 0) begin
      miscompares++;
      $display("FAIL basic_write_count: writes=%0d delay=%0d timeout=%0d, want 8/0/0", nw, nd, to);
    end
    vectors++;
    if (sample_count !== 16'd8 || overflow !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0 || state !== 3'd4) begin
      miscompares++;
      $display("FAIL basic_done_cycle: count=%0d ovf=%b busy=%b wr=%b state=%0d, want 8/0/0/0/4",
               sample_count, overflow, busy, wr_en, state);
    end
    tick();
    vectors++;
    if (state !== 3'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_single_pulse: state=%0d done=%b, want 0/0", state, done);
    end
  endtask

  task automatic test_delay_sw_trigger();
    int nd, nw;
    bit to;
    // trig_in remains high from before arm: no edge, so no trigger
    do_arm(5, 3);
    tick();
    tick();
    tick();
    vectors++;
    if (state !== 3'd1 || wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL held_level_no_trigger: state=%0d wr_en=%b, want 1/0", state, wr_en);
    end
    trig_sw = 1'b1;
    tick();
    vectors++;
    if (state !== 3'd2) begin
      miscompares++;
      $display("FAIL sw_trigger_to_delay: state=%0d, want 2", state);
    end
    run_to_done(nd, nw, to);
    trig_sw = 1'b0;
    vectors++;
    if (to || nd != 3 || nw != 5 || sample_count !== 16'd5) begin
      miscompares++;
      $display("FAIL delay_capture: delay=%0d writes=%0d count=%0d timeout=%0d, want 3/5/5/0", nd, nw, sample_count, to);
    end
    tick();
  endtask

  task automatic test_overflow();
    trig_in = 1'b0;
    tick();
    do_arm(100, 0);
    trig_in = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) tick();
    vectors++;
    if (wr_en !== 1'b1 || sample_count !== 16'd40) begin
      miscompares++;
      $display("FAIL pre_full_progress: wr_en=%b count=%0d, want 1/40", wr_en, sample_count);
    end
    fifo_full = 4'b0100;
    tick();
    fifo_full = 4'b0000;
    vectors++;
    if (wr_en !== 1'b0 || done !== 1'b1 || overflow !== 1'b1 || sample_count !== 16'd41 || state !== 3'd4) begin
      miscompares++;
      $display("FAIL full_early_stop: wr=%b done=%b ovf=%b count=%0d state=%0d, want 0/1/1/41/4",
               wr_en, done, overflow, sample_count, state);
    end
    tick();
    vectors++;
    if (overflow !== 1'b1 || state !== 3'd0) begin
      miscompares++;
      $display("FAIL overflow_sticky: ovf=%b state=%0d, want 1/0", overflow, state);
    end
    do_arm(2, 0);
    vectors++;
    if (overflow !== 1'b0 || sample_count !== 16'd0 || state !== 3'd1) begin
      miscompares++;
      $display("FAIL rearm_clears: ovf=%b count=%0d state=%0d, want 0/0/1", overflow, sample_count, state);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_armed: state=%0d busy=%b, want 0/0", state, busy);
    end
  endtask

  task automatic test_abort();
    do_arm(4, 5);
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (state !== 3'd0 || done !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_delay: state=%0d done=%b wr=%b busy=%b, want 0/0/0/0", state, done, wr_en, busy);
    end
    do_arm(10, 0);
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (state !== 3'd0 || done !== 1'b0 || wr_en !== 1'b0 || sample_count !== 16'd3) begin
      miscompares++;
      $display("FAIL abort_capture: state=%0d done=%b wr=%b count=%0d, want 0/0/0/3", state, done, wr_en, sample_count);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || state !== 3'd0) begin
      miscompares++;
      $display("FAIL abort_no_done: done=%b state=%0d, want 0/0", done, state);
    end
    do_arm(0, 0);
    vectors++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL arm_zero_ignored: state=%0d busy=%b, want 0/0", state, busy);
    end
  endtask

  task automatic test_back_to_back();
    int nw;
    bit to;
    trig_in = 1'b0;
    do_arm(6, 0);
    trig_in = 1'b1;
    tick();
    nw = 0;
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (wr_en) nw++;
      if (done) begin
        to = 1'b0;
        break;
      end
      if (i == 1) trig_in = 1'b0;
      if (i == 2) begin
        trig_in = 1'b1;
        arm = 1'b1;
        nsamples_cfg = 16'd20;
      end
      if (i == 3) arm = 1'b0;
      tick();
    end
    vectors++;
    if (to || nw != 6 || sample_count !== 16'd6) begin
      miscompares++;
      $display("FAIL retrigger_ignored: writes=%0d count=%0d timeout=%0d, want 6/6/0", nw, sample_count, to);
    end
    tick();
    trig_in = 1'b0;
    do_arm(10, 0);
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({wr_en, busy, done, overflow, sample_count, state} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_mid_capture: got %b, want all zero", {wr_en, busy, done, overflow, sample_count, state});
    end
  endtask

  initial begin
    test_reset();
    test_basic_hw_trigger();
    test_delay_sw_trigger();
    test_overflow();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
